// File: rtl/tdm_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_frame_tx_pkg
//  Description : Shared TDM frame constants and frame-counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_frame_tx_pkg;

    localparam int TDM_CLK_DIV          = 6;
    localparam int TDM_BITS_PER_FRAME   = 32;
    localparam int TDM_FRAME_SLOTS      = 2 * TDM_BITS_PER_FRAME + 1;
    localparam int TDM_FRAMES_PER_SUPER = 16;
    localparam int TDM_SLOT_W           = 7;
    localparam logic [TDM_BITS_PER_FRAME-1:0] TDM_IDLE_WORD = 32'hFFFF_FFFF;

    // Wraps at the superframe length rather than at the counter width.
    function automatic logic [3:0] tdm_next_frame(input logic [3:0] idx, input int frames);
        return (int'(idx) == frames - 1) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_c4_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_c4_gen
//  Description : clk50 divider producing c4 and its rise/fall event strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_c4_gen
    import tdm_frame_tx_pkg::*;
#(
    parameter int CLK_DIV = TDM_CLK_DIV
) (
    input  logic clk50,
    input  logic reset,
    input  logic enable,
    output logic c4,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             term;

    // Strobes are combinational so the consumer registers update on the same edge as c4.
    assign term     = enable && (div_cnt == TERM);
    assign rise_evt = term && !c4;
    assign fall_evt = term && c4;

    always_ff @(posedge clk50) begin
        if (reset || !enable) begin
            div_cnt <= '0;
            c4      <= 1'b0;
        end else if (div_cnt == TERM) begin
            div_cnt <= '0;
            c4      <= ~c4;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_frame_tx
//  Description : TDM timing master; serialises one host word per frame, LSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_frame_tx
    import tdm_frame_tx_pkg::*;
#(
    parameter int CLK_DIV          = TDM_CLK_DIV,
    parameter int BITS_PER_FRAME   = TDM_BITS_PER_FRAME,
    parameter int FRAMES_PER_SUPER = TDM_FRAMES_PER_SUPER,
    parameter logic [BITS_PER_FRAME-1:0] IDLE_WORD = TDM_IDLE_WORD
) (
    input  logic                      clk50,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [BITS_PER_FRAME-1:0] word_in,
    input  logic                      word_valid,
    output logic                      word_ready,
    output logic                      c4,
    output logic                      f0,
    output logic                      data_to_dt,
    output logic [3:0]                frame_index,
    output logic                      super_pulse,
    output logic                      underrun
);

    localparam int FRAME_SLOTS = 2 * BITS_PER_FRAME + 1;
    localparam int BIDX_W      = $clog2(BITS_PER_FRAME);
    localparam logic [TDM_SLOT_W-1:0] LAST_SLOT = TDM_SLOT_W'(FRAME_SLOTS - 1);

    logic                      rise_evt;
    logic                      fall_evt;
    logic [TDM_SLOT_W-1:0]     slot;
    logic [TDM_SLOT_W-1:0]     slot_nxt;
    logic [BIDX_W-1:0]         bit_pos;
    logic [BITS_PER_FRAME-1:0] shadow;
    logic [BITS_PER_FRAME-1:0] shift;
    logic                      shadow_full;
    logic                      accept;
    logic                      load;
    logic [3:0]                frame_nxt;

    tdm_c4_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_c4_gen (
        .clk50    (clk50),
        .reset    (reset),
        .enable   (enable),
        .c4       (c4),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt)
    );

    assign word_ready = !shadow_full;
    assign accept     = word_valid && !shadow_full;
    assign slot_nxt   = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    assign load       = fall_evt && (slot == LAST_SLOT);
    assign bit_pos    = BIDX_W'((slot_nxt - 1'b1) >> 1);
    assign frame_nxt  = tdm_next_frame(frame_index, FRAMES_PER_SUPER);

    // The load uses the shadow state from before this cycle's accept, so a word
    // arriving on the load edge waits for the following frame.
    always_ff @(posedge clk50) begin
        if (reset) begin
            shadow_full <= 1'b0;
            shadow      <= '0;
            shift       <= IDLE_WORD;
        end else begin
            if (load) begin
                shift <= shadow_full ? shadow : IDLE_WORD;
            end
            if (load && shadow_full) begin
                shadow_full <= 1'b0;
            end else if (accept) begin
                shadow_full <= 1'b1;
                shadow      <= word_in;
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (reset || !enable) begin
            slot        <= LAST_SLOT;
            f0          <= 1'b1;
            data_to_dt  <= 1'b1;
            frame_index <= 4'd0;
            super_pulse <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            super_pulse <= 1'b0;
            underrun    <= 1'b0;
            if (fall_evt) begin
                slot <= slot_nxt;
                if (slot_nxt == '0) begin
                    f0          <= 1'b0;
                    data_to_dt  <= 1'b1;
                    underrun    <= !shadow_full;
                    frame_index <= frame_nxt;
                    super_pulse <= (frame_nxt == 4'd0);
                end else begin
                    f0 <= 1'b1;
                    // Odd slots start a new bit; even slots hold it for a second c4 period.
                    if (slot_nxt[0]) begin
                        data_to_dt <= shift[bit_pos];
                    end
                end
            end
        end
    end

    a_evt_exclusive : assert property (@(posedge clk50) disable iff (reset) !(rise_evt && fall_evt));

endmodule
`default_nettype wire
